// File: rtl/proc_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, branch conditions,
// FSM states and bus-select encoding.
package proc_core_pkg;

  localparam logic [2:0] OP_MV    = 3'b000;
  localparam logic [2:0] OP_MVT_B = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_CC = 3'b011;
  localparam logic [2:0] COND_CS = 3'b100;
  localparam logic [2:0] COND_PL = 3'b101;
  localparam logic [2:0] COND_MI = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  typedef enum logic [2:0] {FETCH, WAIT, DECODE, E1, E2, E3} state_t;

  // Register selects occupy codes 0..7 so a register index maps directly.
  typedef enum logic [3:0] {
    SEL_R0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_R7,
    SEL_G, SEL_DIN, SEL_D, SEL_MVT
  } bus_sel_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;

  function automatic bus_sel_t reg_sel(input logic [2:0] idx);
    return bus_sel_t'({1'b0, idx});
  endfunction

  function automatic logic cond_true(input logic [2:0] cond, input logic z,
                                     input logic n, input logic c);
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CC: return !c;
      COND_CS: return c;
      COND_PL: return !n;
      COND_MI: return n;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add, subtract (carry = no borrow) and bitwise AND,
// with zero, negative and carry outputs.
module proc_alu
  import proc_core_pkg::*;
#(
  parameter int DW = 16
) (
  input  alu_op_t         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            c,
  output logic            z,
  output logic            n
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
      end
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
        result = sum[DW-1:0];
        c      = sum[DW];
      end
      default: begin
        result = a & b;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);
  assign n = result[DW-1];

endmodule

// File: rtl/proc_core_mc.sv
// Multicycle core with R7 as program counter: fetch, load/store,
// add/sub/and with flags, and conditional relative branches.
module proc_core_mc
  import proc_core_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DOUT,
  output logic          W,
  output logic          Done
);

  state_t        state;
  logic [DW-1:0] regs [8];
  logic [15:0]   ir;
  logic [DW-1:0] a;
  logic [DW-1:0] g;
  logic [DW-1:0] addr_reg;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;

  logic [2:0]    op;
  logic          imm;
  logic [2:0]    rx;
  logic [2:0]    ry;
  logic [DW-1:0] d_imm;
  logic [DW-1:0] mvt_imm;

  bus_sel_t      bus_sel;
  logic [DW-1:0] bus;
  alu_op_t       alu_op;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_z;
  logic          alu_n;

  assign op      = ir[15:13];
  assign imm     = ir[12];
  assign rx      = ir[11:9];
  assign ry      = ir[2:0];
  assign d_imm   = {{(DW-9){ir[8]}}, ir[8:0]};
  assign mvt_imm = {ir[7:0], {(DW-8){1'b0}}};
  assign ADDR    = addr_reg[AW-1:0];

  always_comb begin
    bus_sel = SEL_G;
    case (state)
      FETCH: bus_sel = SEL_R7;
      E1: begin
        case (op)
          OP_MV:                  bus_sel = imm ? SEL_D : reg_sel(ry);
          OP_MVT_B:               bus_sel = imm ? SEL_MVT : SEL_R7;
          OP_ADD, OP_SUB, OP_AND: bus_sel = reg_sel(rx);
          OP_LD, OP_ST:           bus_sel = reg_sel(ry);
          default:                bus_sel = SEL_G;
        endcase
      end
      E2: begin
        case (op)
          OP_ST:    bus_sel = reg_sel(rx);
          OP_MVT_B: bus_sel = SEL_D;
          default:  bus_sel = imm ? SEL_D : reg_sel(ry);
        endcase
      end
      E3: bus_sel = (op == OP_LD) ? SEL_DIN : SEL_G;
      default: bus_sel = SEL_G;
    endcase
  end

  always_comb begin
    case (bus_sel)
      SEL_G:   bus = g;
      SEL_DIN: bus = DIN;
      SEL_D:   bus = d_imm;
      SEL_MVT: bus = mvt_imm;
      default: bus = regs[bus_sel[2:0]];
    endcase
  end

  // Branches reuse the adder to form the target from the incremented PC.
  always_comb begin
    case (op)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  proc_alu #(.DW(DW)) u_alu (
    .op     (alu_op),
    .a      (a),
    .b      (bus),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z),
    .n      (alu_n)
  );

  always_comb begin
    Done = 1'b0;
    case (state)
      E1:      Done = (op == OP_MV) || (op == OP_RSVD) || (op == OP_MVT_B && imm);
      E2:      Done = (op == OP_ST);
      E3:      Done = 1'b1;
      default: Done = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= FETCH;
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7]  <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      g        <= '0;
      addr_reg <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      DOUT     <= '0;
      W        <= 1'b0;
    end else begin
      W <= 1'b0;
      case (state)
        FETCH: begin
          if (Run) begin
            addr_reg <= bus;
            regs[7]  <= regs[7] + DW'(1);
            state    <= WAIT;
          end
        end
        WAIT: state <= DECODE;
        DECODE: begin
          ir    <= DIN[15:0];
          state <= E1;
        end
        E1: begin
          state <= E2;
          case (op)
            OP_MV: begin
              regs[rx] <= bus;
              state    <= FETCH;
            end
            OP_MVT_B: begin
              if (imm) begin
                regs[rx] <= bus;
                state    <= FETCH;
              end else begin
                a <= bus;
              end
            end
            OP_ADD, OP_SUB, OP_AND: a <= bus;
            OP_LD, OP_ST:           addr_reg <= bus;
            default:                state <= FETCH;
          endcase
        end
        E2: begin
          state <= E3;
          case (op)
            OP_ADD, OP_SUB, OP_AND: begin
              g      <= alu_res;
              flag_z <= alu_z;
              flag_n <= alu_n;
              flag_c <= alu_c;
            end
            OP_MVT_B: g <= alu_res;
            OP_ST: begin
              DOUT  <= bus;
              W     <= 1'b1;
              state <= FETCH;
            end
            default: ;
          endcase
        end
        E3: begin
          state <= FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_LD: regs[rx] <= bus;
            OP_MVT_B: if (cond_true(rx, flag_z, flag_n, flag_c)) regs[7] <= bus;
            default: ;
          endcase
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_mc.sv
// Directed bench for proc_core_mc: small programs in a 1-cycle-latency
// memory model, checking registers, flags, bus activity and latencies.
module tb_proc_core_mc;
  import proc_core_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b0;
  logic          Run    = 1'b0;
  logic [DW-1:0] DIN;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DOUT;
  logic          W;
  logic          Done;

  logic [15:0]   mem   [256];
  logic [15:0]   image [256];

  int            total = 0;
  int            bad   = 0;
  int            w_count;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_dout;
  int            lat [16];
  int            sub_count;
  int            viol;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] r7_hold;

  proc_core_mc #(.DW(DW), .AW(AW), .RESET_PC(16'h0000)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .ADDR   (ADDR),
    .DOUT   (DOUT),
    .W      (W),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  // Memory reloads the program image while reset is held.
  always @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (W) begin
      mem[ADDR[7:0]] <= DOUT;
    end
    DIN <= mem[ADDR[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 256; i++) image[i] = 16'h0000;
  endtask

  task automatic applyStimulus(input logic run_en);
    Resetn = 1'b0;
    Run    = run_en;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
  endtask

  task automatic runDones(input int n, input int budget);
    int cyc;
    int seen;
    int spent;
    cyc = 0;
    seen = 0;
    spent = 0;
    w_count = 0;
    while (seen < n && spent < budget) begin
      @(negedge Clock);
      spent++;
      cyc++;
      if (W) begin
        w_count++;
        w_addr = ADDR;
        w_dout = DOUT;
      end
      if (Done) begin
        if (seen < 16) lat[seen] = cyc;
        if (dut.ir == 16'h7001) sub_count++;
        cyc = 0;
        seen++;
      end
    end
    if (seen < n) checkOutput("done_timeout", 32'(seen), 32'(n));
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset in the middle of an add
    clearImage();
    image[0] = 16'h1005;
    image[1] = 16'h5001;
    image[2] = 16'h21FF;
    applyStimulus(1'b1);
    for (int i = 0; i < 20 && dut.state != E2; i++) @(negedge Clock);
    checkOutput("reach_e2", 32'(dut.state == E2), 1);
    checkOutput("pre_r0", 32'(dut.regs[0]), 5);
    Resetn = 1'b0;
    #1;
    checkOutput("rst_r0", 32'(dut.regs[0]), 0);
    checkOutput("rst_r7", 32'(dut.regs[7]), 0);
    checkOutput("rst_a", 32'(dut.a), 0);
    checkOutput("rst_addr", 32'(ADDR), 0);
    checkOutput("rst_W", 32'(W), 0);
    checkOutput("rst_Done", 32'(Done), 0);
    checkOutput("rst_state", 32'(dut.state == FETCH), 1);
    @(posedge Clock);
    #1 Resetn = 1'b1;
    @(posedge Clock);
    #1;
    checkOutput("first_addr", 32'(ADDR), 0);
    checkOutput("first_r7", 32'(dut.regs[7]), 1);

    // Countdown loop: mv r0,#5 / sub r0,#1 / bne -2
    clearImage();
    image[0] = 16'h1005;
    image[1] = 16'h7001;
    image[2] = 16'h25FE;
    image[3] = 16'h21FF;
    applyStimulus(1'b1);
    sub_count = 0;
    runDones(11, 300);
    checkOutput("loop_subs", 32'(sub_count), 5);
    checkOutput("loop_r0", 32'(dut.regs[0]), 0);
    checkOutput("loop_z", 32'(dut.flag_z), 1);
    checkOutput("loop_r7", 32'(dut.regs[7]), 3);
    checkOutput("loop_lat_mv", 32'(lat[0]), 4);
    checkOutput("loop_lat_b", 32'(lat[2]), 6);

    // mvt, store, load round trip
    clearImage();
    image[0] = 16'h32AB;
    image[1] = 16'h1420;
    image[2] = 16'hA202;
    image[3] = 16'h8602;
    image[4] = 16'h21FF;
    applyStimulus(1'b1);
    runDones(4, 100);
    checkOutput("st_w_count", 32'(w_count), 1);
    checkOutput("st_addr", 32'(w_addr), 'h20);
    checkOutput("st_dout", 32'(w_dout), 'hAB00);
    checkOutput("mvt_r1", 32'(dut.regs[1]), 'hAB00);
    checkOutput("st_mem", 32'(mem[8'h20]), 'hAB00);
    checkOutput("ld_r3", 32'(dut.regs[3]), 'hAB00);

    // Flags from add and sub, then Run gating
    clearImage();
    image[0] = 16'h19FF;
    image[1] = 16'h5801;
    image[2] = 16'h7801;
    image[3] = 16'h21FF;
    applyStimulus(1'b1);
    runDones(2, 60);
    checkOutput("add_r4", 32'(dut.regs[4]), 0);
    checkOutput("add_z", 32'(dut.flag_z), 1);
    checkOutput("add_c", 32'(dut.flag_c), 1);
    checkOutput("add_n", 32'(dut.flag_n), 0);
    runDones(1, 30);
    checkOutput("sub_r4", 32'(dut.regs[4]), 'hFFFF);
    checkOutput("sub_n", 32'(dut.flag_n), 1);
    checkOutput("sub_c", 32'(dut.flag_c), 0);
    checkOutput("sub_z", 32'(dut.flag_z), 0);
    Run = 1'b0;
    addr_hold = ADDR;
    r7_hold = dut.regs[7];
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (ADDR !== addr_hold || dut.regs[7] !== r7_hold || W !== 1'b0 || Done !== 1'b0)
        viol++;
    end
    checkOutput("run_gate_viol", 32'(viol), 0);
    checkOutput("run_gate_addr", 32'(ADDR), 2);
    checkOutput("run_gate_r7", 32'(dut.regs[7]), 3);
    @(posedge Clock);
    #1 Run = 1'b1;
    runDones(1, 30);
    checkOutput("halt_r7", 32'(dut.regs[7]), 3);

    // Per-instruction latency: mv, st, add, ld, b
    clearImage();
    image[0] = 16'h1230;
    image[1] = 16'hA201;
    image[2] = 16'h5002;
    image[3] = 16'h8401;
    image[4] = 16'h2000;
    image[5] = 16'h21FF;
    applyStimulus(1'b1);
    runDones(5, 100);
    checkOutput("lat_mv", 32'(lat[0]), 4);
    checkOutput("lat_st", 32'(lat[1]), 5);
    checkOutput("lat_add", 32'(lat[2]), 6);
    checkOutput("lat_ld", 32'(lat[3]), 6);
    checkOutput("lat_b", 32'(lat[4]), 6);
    checkOutput("cc_r0", 32'(dut.regs[0]), 2);
    checkOutput("cc_r2", 32'(dut.regs[2]), 'h30);
    checkOutput("cc_r7", 32'(dut.regs[7]), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_core_mc.md
Name: proc_core_mc

Overview:
- Parametrised multicycle processor core: the next generation of our 4-instruction datapath (mv/mvt/add/sub).
- Adds an instruction fetch from memory, with R7 as program counter.
- Adds load/store over a synchronous memory port, a bitwise AND, condition flags, and conditional branches.
- Sits between the on-chip RAM (1-cycle read latency) and the memory-mapped peripherals. A top level ties `Run` high for free-running execution.

Parameters:
- `DW`, 16: datapath/register width; must be ≥16. Instructions are always 16 bits (`DIN[15:0]`).
- `AW`, 16: memory address width, AW ≤ DW. `ADDR` = addr_reg[AW-1:0].
- `RESET_PC`, 0: R7 value after reset.

Ports:
- `Clock`  in  1  system clock, rising-edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Run`  in  1  enables fetch of the next instruction; sampled in FETCH only.
- `DIN`  in  DW  memory read data; valid the second cycle after `ADDR` is loaded.
- `ADDR`  out  AW  registered memory address.
- `DOUT`  out  DW  registered store data.
- `W`  out  1  registered write strobe; memory writes `DOUT` to `ADDR` on the edge ending a `W`=1 cycle.
- `Done`  out  1  combinational, high during the final cycle of each instruction.

Behaviour:

Instruction format (fixed 16-bit IR):
- Fields: op=IR[15:13], imm=IR[12], rX=IR[11:9], rY=IR[2:0].
- Immediate: D = sign-extend(IR[8:0]) to DW.

Opcodes:
- 000 mv: rX ← rY/D.
- 001, imm=1 → mvt: rX ← {IR[7:0], (DW-8) zeros}.
- 001, imm=0 → b{cond}: cond=IR[11:9].
  - Codes: 000 always, 001 eq(z), 010 ne(!z), 011 cc(!c), 100 cs(c), 101 pl(!n), 110 mi(n), 111 never.
- 010 add: rX ← rX + rY/D.
- 011 sub: rX ← rX − rY/D.
- 100 ld: rX ← mem[rY].
- 101 st: mem[rY] ← rX.
- 110 and: rX ← rX & rY/D.
- 111 reserved: no operation, `Done` only.

Flags (z, n, c):
- Updated only by add/sub/and, in the cycle G is loaded.
- z = (result == 0); n = result[DW-1].
- c = carry-out of the DW-bit add. For sub, c = carry-out of rX + ~op + 1, i.e. 1 = no borrow.
- and clears c.
- All arithmetic is modulo 2^DW.

FSM states: FETCH, WAIT, DECODE, E1, E2, E3.
- FETCH
  - If `Run`=0: stay in FETCH, no register changes.
  - Else: bus=R7 → addr_reg; R7 ← R7+1 (wraps at 2^DW); go to WAIT.
- WAIT: idle; memory read in flight; go to DECODE.
- DECODE: IR ← `DIN`; go to E1.
- mv / mvt / reserved: E1 writes rX where applicable; `Done`=1; next FETCH.
- add / sub / and:
  - E1: A ← rX.
  - E2: G ← ALU(A, rY/D); flags load.
  - E3: rX ← G; `Done`=1.
- b:
  - E1: A ← R7 (already incremented).
  - E2: G ← A + D; flags unchanged.
  - E3: if cond is true, R7 ← G; `Done`=1.
- ld:
  - E1: addr_reg ← rY.
  - E2: wait.
  - E3: rX ← `DIN`; `Done`=1.
- st:
  - E1: addr_reg ← rY.
  - E2: DOUT ← rX, `W` ← 1 (registered; high for exactly the cycle after E2); `Done`=1; next FETCH.
  - A FETCH following a store cannot change `ADDR` before the write edge, because addr_reg loads at the end of FETCH.
- Any instruction writing rX=R7 (mv/add/ld) is a jump. Such a write overrides the FETCH increment, since the two never occur in the same cycle.
- Latency in cycles, FETCH through last state: mv/mvt/reserved 4; st 5; add/sub/and/b/ld 6.

Reset (asynchronous, any state, mid-instruction included):
- State=FETCH.
- R0–R6=0, R7=`RESET_PC`, IR=0, A=G=0, flags=0, addr_reg=0, `DOUT`=0, `W`=0.
- `Done`=0.
- An aborted st must not assert `W`.

Decomposition:
- Package proc_core_pkg:
  - opcode constants;
  - branch condition codes;
  - FSM state enum;
  - bus-select encoding (R0–R7, G, DIN, D, mvt-immediate).
- One sub-module, proc_alu: combinational add/sub/and, producing a DW-bit result plus c, z, n.
- Registers, bus multiplexer and FSM stay in proc_core_mc.

Test Plan (memory model: 1-cycle read latency, DW=16):
- Reset: hold `Resetn`=0 mid-E2 of an add → all registers 0, R7=`RESET_PC`, `W`=0, `Done`=0; after release, first `ADDR`=`RESET_PC`.
- Loop: program 0x1005 (mv r0,#5), 0x7001 (sub r0,#1), 0x25FE (bne −2) → body executes 5 times; final r0=0, z=1; R7=3 after the fall-through.
- mvt / st / ld:
  - Code: 0x32AB (mvt r1,#0xAB), mv r2,#0x20, 0xA202 (st r1,[r2]), 0x8602 (ld r3,[r2]).
  - Expect: `W` high exactly one cycle with `ADDR`=0x20, `DOUT`=0xAB00; then r3=0xAB00.
- Flags: 0x19FF (mv r4,#−1) then 0x5801 (add r4,#1) → r4=0, z=1, c=1, n=0; then sub r4,#1 → r4=0xFFFF, n=1, c=0.
- `Run` gating: `Run`=0 in FETCH for 10 cycles → `ADDR`, R7 and `W` stable; `Done` never asserted.
- Cycle counts: one each of mv, st, add, ld, b → `Done` asserted after 4, 5, 6, 6 and 6 cycles respectively.
